// File: rtl/tdes_cbc_ctrl_pkg.sv
// Shared types and constants for the TDES CBC chaining controller.
// Blocks are [0:63] with bit 0 as the MSB, matching the tdes core.
package tdes_cbc_ctrl_pkg;

    typedef logic [0:63] block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Chaining XOR that collapses to a pass-through when chaining is disabled.
    function automatic block_t cbc_xor(input block_t a, input block_t b, input logic en);
        return en ? (a ^ b) : a;
    endfunction

endpackage

// File: rtl/tdes_cbc_ctrl.sv
// CBC chaining stage in front of the tdes core: one block in flight, encrypt and decrypt,
// with ECB pass-through when CHAIN_EN is 0.
module tdes_cbc_ctrl
    import tdes_cbc_ctrl_pkg::*;
#(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mode_i,
    input  logic        start_i,
    input  logic [0:63] iv_i,
    input  logic [0:63] data_i,
    input  logic        valid_i,
    output logic        accept_o,
    output logic [0:63] data_o,
    output logic        valid_o,
    output logic        core_mode_o,
    output logic [0:63] core_data_o,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    input  logic [0:63] core_data_i,
    input  logic        core_valid_i,
    output logic        err_o
);

    state_e state_q, state_d;
    logic   accept_q, accept_d;
    logic   mode_q, mode_d;
    block_t chain_q, chain_d;
    block_t cbuf_q, cbuf_d;
    block_t cdata_q, cdata_d;
    logic   cvalid_q, cvalid_d;
    block_t dout_q, dout_d;
    logic   dvalid_q, dvalid_d;
    logic   err_q, err_d;

    block_t cv;
    logic   mode_n;

    always_comb begin
        state_d  = state_q;
        accept_d = accept_q;
        mode_d   = mode_q;
        chain_d  = chain_q;
        cbuf_d   = cbuf_q;
        cdata_d  = cdata_q;
        cvalid_d = cvalid_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        err_d    = err_q | (core_valid_i && (state_q != ST_WAIT));

        cv     = (CHAIN_EN && start_i) ? iv_i : chain_q;
        mode_n = start_i ? mode_i : mode_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    mode_d = mode_n;
                    if (mode_n == MODE_ENC) begin
                        cdata_d = cbc_xor(data_i, cv, CHAIN_EN);
                    end else begin
                        cdata_d = data_i;
                        if (CHAIN_EN) cbuf_d = data_i;
                    end
                    if (CHAIN_EN) chain_d = cv;
                    accept_d = 1'b0;
                    cvalid_d = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (core_ready_i) begin
                    cvalid_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_valid_i) begin
                    if (mode_q == MODE_ENC) begin
                        dout_d = core_data_i;
                        if (CHAIN_EN) chain_d = core_data_i;
                    end else begin
                        dout_d = cbc_xor(core_data_i, chain_q, CHAIN_EN);
                        if (CHAIN_EN) chain_d = cbuf_q;
                    end
                    dvalid_d = 1'b1;
                    accept_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                accept_d = 1'b1;
                cvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            accept_q <= 1'b1;
            mode_q   <= MODE_ENC;
            chain_q  <= '0;
            cbuf_q   <= '0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept_d;
            mode_q   <= mode_d;
            chain_q  <= chain_d;
            cbuf_q   <= cbuf_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    // accept_q already holds its post-reset value; gating keeps the port low while reset is held.
    assign accept_o     = accept_q & ~reset_i;
    assign data_o       = dout_q;
    assign valid_o      = dvalid_q;
    assign core_mode_o  = mode_q;
    assign core_data_o  = cdata_q;
    assign core_valid_o = cvalid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_tdes_cbc_ctrl.sv
// Bench for tdes_cbc_ctrl: a CBC (CHAIN_EN=1) and an ECB (CHAIN_EN=0) instance share host stimulus
// and a stand-in core whose cipher is x ^ K (matches single DES for the 0x0123456789ABCDEF vector).
module tb_tdes_cbc_ctrl;

    localparam logic [0:63] K    = 64'h84CB563386A179EA;
    localparam logic [0:63] P1   = 64'h0123456789ABCDEF;
    localparam logic [0:63] P2   = 64'h84CB563386A179EA;
    localparam logic [0:63] C1   = 64'h85E813540F0AB405;
    localparam logic [0:63] ONES = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        mode_i = 1'b0, start_i = 1'b0, valid_i = 1'b0;
    logic [0:63] iv_i = '0, data_i = '0;

    logic        accept_o[2], valid_o[2], core_mode_o[2], core_valid_o[2], err_o[2];
    logic [0:63] data_o[2], core_data_o[2], core_data_i[2];
    logic        core_ready_i = 1'b0, core_valid_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdes_cbc_ctrl #(.CHAIN_EN(1'b1)) dut_cbc (
        .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .start_i(start_i), .iv_i(iv_i),
        .data_i(data_i), .valid_i(valid_i), .accept_o(accept_o[0]), .data_o(data_o[0]),
        .valid_o(valid_o[0]), .core_mode_o(core_mode_o[0]), .core_data_o(core_data_o[0]),
        .core_valid_o(core_valid_o[0]), .core_ready_i(core_ready_i), .core_data_i(core_data_i[0]),
        .core_valid_i(core_valid_i), .err_o(err_o[0]));

    tdes_cbc_ctrl #(.CHAIN_EN(1'b0)) dut_ecb (
        .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .start_i(start_i), .iv_i(iv_i),
        .data_i(data_i), .valid_i(valid_i), .accept_o(accept_o[1]), .data_o(data_o[1]),
        .valid_o(valid_o[1]), .core_mode_o(core_mode_o[1]), .core_data_o(core_data_o[1]),
        .core_valid_o(core_valid_o[1]), .core_ready_i(core_ready_i), .core_data_i(core_data_i[1]),
        .core_valid_i(core_valid_i), .err_o(err_o[1]));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [0:63] ref_cipher(input logic [0:63] x);
        return x ^ K;
    endfunction

    // ---------------- stand-in core ----------------
    int          ready_delay = 0, core_lat = 1, wait_cnt = 0, ret_cnt = 0, hs_cnt = 0;
    logic        stray_req = 1'b0;
    logic [0:63] cap[2];

    initial begin
        cap[0] = '0; cap[1] = '0; core_data_i[0] = '0; core_data_i[1] = '0;
        forever begin
            @(posedge clk); #2;
            core_valid_i = 1'b0;
            if (reset_i) begin
                core_ready_i = 1'b0; wait_cnt = 0; ret_cnt = 0;
            end else begin
                if (stray_req) begin
                    core_valid_i = 1'b1; stray_req = 1'b0;
                end
                if (ret_cnt > 0) begin
                    ret_cnt--;
                    if (ret_cnt == 0) begin
                        core_valid_i = 1'b1;
                        for (int i = 0; i < 2; i++) core_data_i[i] = ref_cipher(cap[i]);
                    end
                end
                if (core_valid_o[0] && !core_ready_i) begin
                    if (wait_cnt >= ready_delay) begin
                        core_ready_i = 1'b1;
                        for (int i = 0; i < 2; i++) cap[i] = core_data_o[i];
                    end else wait_cnt++;
                end else if (core_ready_i) begin
                    core_ready_i = 1'b0; wait_cnt = 0; ret_cnt = core_lat; hs_cnt++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Results are computed at accept time from the CBC equations; the core handshake only gates timing.
    logic        m_busy = 1'b0, m_sent = 1'b0, m_cv = 1'b0, m_err = 1'b0, m_mode = 1'b0, m_valid = 1'b0;
    logic [0:63] m_prev[2], m_cdata[2], m_data[2];
    logic [0:63] m_q0[$], m_q1[$];

    always @(posedge clk) begin
        logic hs, legit, xfer;
        logic [0:63] res, snd;
        m_valid = 1'b0;
        if (reset_i) begin
            m_busy = 1'b0; m_sent = 1'b0; m_cv = 1'b0; m_err = 1'b0; m_mode = 1'b0;
            for (int i = 0; i < 2; i++) begin m_prev[i] = '0; m_cdata[i] = '0; m_data[i] = '0; end
            m_q0.delete(); m_q1.delete();
        end else begin
            hs    = m_busy && m_cv && core_ready_i;
            legit = core_valid_i && m_busy && m_sent;
            xfer  = valid_i && !m_busy;
            if (core_valid_i && !legit) m_err = 1'b1;
            if (hs) begin m_cv = 1'b0; m_sent = 1'b1; end
            if (legit) begin
                m_valid = 1'b1; m_busy = 1'b0; m_sent = 1'b0;
                m_data[0] = m_q0.pop_front();
                m_data[1] = m_q1.pop_front();
            end
            if (xfer) begin
                if (start_i) begin m_mode = mode_i; m_prev[0] = iv_i; end
                for (int i = 0; i < 2; i++) begin
                    if (m_mode == 1'b0) begin
                        snd = (i == 0) ? (data_i ^ m_prev[i]) : data_i;
                        res = ref_cipher(snd);
                        if (i == 0) m_prev[i] = res;
                    end else begin
                        snd = data_i;
                        res = ref_cipher(data_i) ^ ((i == 0) ? m_prev[i] : '0);
                        if (i == 0) m_prev[i] = data_i;
                    end
                    m_cdata[i] = snd;
                    if (i == 0) m_q0.push_back(res); else m_q1.push_back(res);
                end
                m_busy = 1'b1; m_cv = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int          out_cnt[2] = '{0, 0};
    logic [0:63] last_out[2];

    always begin
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("accept_o[%0d]", i), 64'(accept_o[i]), 64'(!reset_i && !m_busy));
            chk($sformatf("valid_o[%0d]", i), 64'(valid_o[i]), 64'(m_valid));
            chk($sformatf("data_o[%0d]", i), data_o[i], m_data[i]);
            chk($sformatf("core_valid_o[%0d]", i), 64'(core_valid_o[i]), 64'(m_cv));
            chk($sformatf("core_data_o[%0d]", i), core_data_o[i], m_cdata[i]);
            chk($sformatf("core_mode_o[%0d]", i), 64'(core_mode_o[i]), 64'(m_mode));
            chk($sformatf("err_o[%0d]", i), 64'(err_o[i]), 64'(m_err));
            if (valid_o[i]) begin
                out_cnt[i]++;
                last_out[i] = data_o[i];
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic st, input logic md, input logic [0:63] iv, input logic [0:63] d);
        int n = 0;
        @(negedge clk);
        start_i = st; mode_i = md; iv_i = iv; data_i = d; valid_i = 1'b1;
        while (!accept_o[0] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (out_cnt[0] < target && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("output_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_check(input string name, input logic st, input logic md,
                              input logic [0:63] iv, input logic [0:63] d, input logic [0:63] exp, input int idx);
        int base = out_cnt[0];
        send(st, md, iv, d);
        wait_out(base + 1);
        chk(name, last_out[idx], exp);
    endtask

    initial begin
        int base, hs0, n;
        last_out[0] = '0; last_out[1] = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("reset_accept", 64'(accept_o[0]), 64'd1);
        chk("reset_data", data_o[0], 64'd0);

        // 1, 2: CBC encrypt chain
        send_check("enc_block1", 1'b1, 1'b0, '0, P1, C1, 0);
        send_check("enc_block2", 1'b0, 1'b0, '0, P2, C1, 0);
        chk("enc_block2_core_in", cap[0], P1);

        // 3: CBC decrypt chain
        send_check("dec_block1", 1'b1, 1'b1, '0, C1, P1, 0);
        send_check("dec_block2", 1'b0, 1'b1, '0, C1, P2, 0);
        chk("dec_core_mode", 64'(core_mode_o[0]), 64'd1);

        // 4: valid_i held through busy period, host data changing, core ready delayed
        ready_delay = 5;
        base = out_cnt[0]; hs0 = hs_cnt; n = 0;
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; iv_i = '0; data_i = P1; valid_i = 1'b1;
        while (!accept_o[0] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        start_i = 1'b0; data_i = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        data_i = 64'h5555AAAA5555AAAA;
        @(negedge clk);
        data_i = P2;
        wait_out(base + 1);
        chk("held_block1", last_out[0], C1);
        n = 0;
        while (!accept_o[0] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        valid_i = 1'b0;
        wait_out(base + 2);
        chk("held_block2", last_out[0], C1);
        chk("held_handshakes", 64'(hs_cnt - hs0), 64'd2);
        chk("held_outputs", 64'(out_cnt[0] - base), 64'd2);
        ready_delay = 0;

        // 5: reset during WAIT discards pending block
        core_lat = 4;
        hs0 = hs_cnt; base = out_cnt[0]; n = 0;
        send(1'b1, 1'b0, '0, P1);
        while (hs_cnt == hs0 && n < 100) begin @(negedge clk); n++; end
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_no_output", 64'(out_cnt[0] - base), 64'd0);
        chk("reset_release_accept", 64'(accept_o[0]), 64'd1);
        core_lat = 1;
        send_check("after_reset_enc", 1'b1, 1'b0, '0, P1, C1, 0);

        // 6: ECB ignores IV and chaining; stray core_valid_i flags an error
        send_check("ecb_block1", 1'b1, 1'b0, ONES, P1, C1, 1);
        send_check("ecb_block2", 1'b0, 1'b0, ONES, P1, C1, 1);
        chk("err_clear", 64'(err_o[1]), 64'd0);
        @(negedge clk);
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_sticky_ecb", 64'(err_o[1]), 64'd1);
        chk("err_sticky_cbc", 64'(err_o[0]), 64'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1);
    end

endmodule
